// File: rtl/store_size_seq.sv
// Read-modify-write sequencer for sub-word stores (SB/SH); SW writes directly.
// Outputs are registered Moore outputs and clear asynchronously with reset.
module store_size_seq #(
    parameter int MEM_LAT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] store_type,
    input  logic [1:0] addr_low,
    output logic       busy,
    output logic       mem_rd,
    output logic       mdr_load,
    output logic       mem_wr,
    output logic [1:0] controleSS,
    output logic       done,
    output logic       err
);

    // state | meaning
    // IDLE  | waiting for start
    // READ  | mem_rd held for MEM_LAT cycles
    // LATCH | mdr_load pulse, read data captured
    // WRITE | mem_wr pulse, merged word written back
    // DONE  | done pulse
    // ERR   | err pulse, request rejected without memory access
    typedef enum logic [2:0] {
        IDLE,
        READ,
        LATCH,
        WRITE,
        DONE,
        ERR
    } state_t;

    localparam logic [1:0] TYPE_SW = 2'b00;
    localparam logic [1:0] TYPE_SB = 2'b01;
    localparam logic [1:0] TYPE_SH = 2'b10;

    state_t     state;
    logic [3:0] cnt;
    logic       legal;

    always_comb begin
        legal = 1'b0;
        case (store_type)
            TYPE_SW: legal = (addr_low == 2'b00);
            TYPE_SB: legal = 1'b1;
            TYPE_SH: legal = ~addr_low[0];
            default: legal = 1'b0;
        endcase
    end

    // controleSS doubles as the captured store type for the whole sequence.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            busy       <= 1'b0;
            mem_rd     <= 1'b0;
            mdr_load   <= 1'b0;
            mem_wr     <= 1'b0;
            controleSS <= 2'b00;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            mdr_load <= 1'b0;
            mem_wr   <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (!legal) begin
                            state <= ERR;
                            err   <= 1'b1;
                        end else if (store_type == TYPE_SW) begin
                            state      <= WRITE;
                            mem_wr     <= 1'b1;
                            controleSS <= TYPE_SW;
                        end else begin
                            state      <= READ;
                            mem_rd     <= 1'b1;
                            cnt        <= 4'(MEM_LAT - 1);
                            controleSS <= store_type;
                        end
                    end
                end
                READ: begin
                    if (cnt == 4'd0) begin
                        state    <= LATCH;
                        mem_rd   <= 1'b0;
                        mdr_load <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                LATCH: begin
                    state  <= WRITE;
                    mem_wr <= 1'b1;
                end
                WRITE: begin
                    state <= DONE;
                    done  <= 1'b1;
                end
                DONE: begin
                    state      <= IDLE;
                    busy       <= 1'b0;
                    controleSS <= 2'b00;
                end
                ERR: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state      <= IDLE;
                    busy       <= 1'b0;
                    mem_rd     <= 1'b0;
                    controleSS <= 2'b00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_store_size_seq.sv
// Bench for store_size_seq: two instances (MEM_LAT 1 and 3) share stimulus and
// are compared each cycle against a timeline model of each accepted request.
module tb_store_size_seq;

    logic       clk;
    logic       reset;
    logic       start;
    logic [1:0] store_type;
    logic [1:0] addr_low;

    logic       busy_a, mem_rd_a, mdr_load_a, mem_wr_a, done_a, err_a;
    logic [1:0] ctrl_a;
    logic       busy_b, mem_rd_b, mdr_load_b, mem_wr_b, done_b, err_b;
    logic [1:0] ctrl_b;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // per-instance record of the request currently in flight
    bit       op_act  [2];
    int       op_s    [2];
    bit [1:0] op_type [2];
    bit       op_legal[2];
    int       lat     [2];

    store_size_seq #(.MEM_LAT(1)) dut_a (
        .clk(clk), .reset(reset), .start(start), .store_type(store_type),
        .addr_low(addr_low), .busy(busy_a), .mem_rd(mem_rd_a),
        .mdr_load(mdr_load_a), .mem_wr(mem_wr_a), .controleSS(ctrl_a),
        .done(done_a), .err(err_a)
    );

    store_size_seq #(.MEM_LAT(3)) dut_b (
        .clk(clk), .reset(reset), .start(start), .store_type(store_type),
        .addr_low(addr_low), .busy(busy_b), .mem_rd(mem_rd_b),
        .mdr_load(mdr_load_b), .mem_wr(mem_wr_b), .controleSS(ctrl_b),
        .done(done_b), .err(err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d obs={busy,rd,ld,wr,ss,done,err}=%b want=%b",
                     tag, cyc, obs, exp);
        end
    endtask

    function automatic bit is_legal(input bit [1:0] t, input bit [1:0] a);
        if (t == 2'b11) return 1'b0;
        if (t == 2'b10) return a[0] == 1'b0;
        if (t == 2'b00) return a == 2'b00;
        return 1'b1;
    endfunction

    function automatic int op_len(input int i);
        if (!op_legal[i]) return 1;
        if (op_type[i] == 2'b00) return 2;
        return lat[i] + 3;
    endfunction

    // Expected outputs at cycle c: {busy, mem_rd, mdr_load, mem_wr, controleSS, done, err}
    function automatic logic [7:0] model_out(input int i, input int c);
        int k;
        int L;
        logic [7:0] r;
        r = 8'h00;
        if (!op_act[i]) return r;
        k = c - op_s[i];
        L = lat[i];
        if (k < 1 || k > op_len(i)) return r;
        r[7] = 1'b1;
        if (!op_legal[i]) begin
            r[0] = 1'b1;
        end else if (op_type[i] == 2'b00) begin
            r[4] = (k == 1);
            r[1] = (k == 2);
        end else begin
            r[3:2] = op_type[i];
            r[6] = (k <= L);
            r[5] = (k == L + 1);
            r[4] = (k == L + 2);
            r[1] = (k == L + 3);
        end
        return r;
    endfunction

    function automatic bit model_idle(input int i, input int c);
        return !op_act[i] || (c - op_s[i] > op_len(i));
    endfunction

    // One clock: model decides acceptance on the current inputs, then outputs of
    // the following cycle are compared just after the edge.
    task automatic step();
        for (int i = 0; i < 2; i++) begin
            if (start && reset && model_idle(i, cyc)) begin
                op_act[i]   = 1'b1;
                op_s[i]     = cyc;
                op_type[i]  = store_type;
                op_legal[i] = is_legal(store_type, addr_low);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        check("lat1", {busy_a, mem_rd_a, mdr_load_a, mem_wr_a, ctrl_a, done_a, err_a}, model_out(0, cyc));
        check("lat3", {busy_b, mem_rd_b, mdr_load_b, mem_wr_b, ctrl_b, done_b, err_b}, model_out(1, cyc));
    endtask

    task automatic req(input logic [1:0] t, input logic [1:0] a, input int idle_after);
        start      = 1'b1;
        store_type = t;
        addr_low   = a;
        step();
        start = 1'b0;
        for (int j = 0; j < idle_after; j++) step();
    endtask

    initial begin
        lat[0] = 1;
        lat[1] = 3;
        op_act[0] = 1'b0;
        op_act[1] = 1'b0;
        reset = 1'b0;
        start = 1'b0;
        store_type = 2'b00;
        addr_low   = 2'b00;

        for (int j = 0; j < 3; j++) step();
        @(negedge clk);
        reset = 1'b1;

        // directed cases from the plan
        req(2'b00, 2'b00, 3);
        req(2'b01, 2'b11, 7);
        req(2'b10, 2'b10, 7);
        req(2'b10, 2'b01, 2);
        req(2'b11, 2'b00, 2);
        req(2'b00, 2'b10, 2);

        // start held high during an SB sequence
        start = 1'b1;
        store_type = 2'b01;
        addr_low = 2'b00;
        for (int j = 0; j < 4; j++) step();
        start = 1'b0;
        for (int j = 0; j < 5; j++) step();

        // back-to-back SW: second start lands in the first IDLE cycle after done
        req(2'b00, 2'b00, 2);
        req(2'b00, 2'b00, 3);

        // reset between edges while mem_wr is high
        req(2'b00, 2'b00, 0);
        #2;
        reset = 1'b0;
        #1;
        check("rst_a", {busy_a, mem_rd_a, mdr_load_a, mem_wr_a, ctrl_a, done_a, err_a}, 8'h00);
        check("rst_b", {busy_b, mem_rd_b, mdr_load_b, mem_wr_b, ctrl_b, done_b, err_b}, 8'h00);
        op_act[0] = 1'b0;
        op_act[1] = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        step();
        req(2'b00, 2'b00, 3);

        // random traffic, including starts while busy and in the done cycle
        for (int j = 0; j < 600; j++) begin
            @(negedge clk);
            start      = ($urandom_range(0, 2) == 0);
            store_type = 2'($urandom_range(0, 3));
            addr_low   = 2'($urandom_range(0, 3));
            step();
        end
        start = 1'b0;
        for (int j = 0; j < 8; j++) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/store_size_seq.md
Name: store_size_seq

Overview:
- Multicycle sequencer for a store-size merge unit. It runs the read-modify-write needed for sub-word stores (SB/SH).
- For SB/SH: reads the target word into the memory data register, drives the merge select while the merged word is written back.
- For SW: skips the read and writes B directly.
- Sits between the main control FSM (which issues start/store_type) and the memory, memory data register and merge unit.

Parameters:
- MEM_LAT, 1, memory read latency in cycles. Legal range 1..15. Number of cycles mem_rd is held before the data register is loaded.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request from the main FSM. Sampled only in IDLE.
- store_type  input  2  00 = SW, 01 = SB, 10 = SH, 11 = illegal.
- addr_low  input  2  address bits [1:0] of the store, sampled with start.
- busy  output  1  high in every state except IDLE.
- mem_rd  output  1  memory read enable.
- mdr_load  output  1  load enable for the memory data register.
- mem_wr  output  1  memory write enable.
- controleSS  output  2  merge select: 00 word, 01 byte, 10 half.
- done  output  1  one-cycle pulse, store completed.
- err  output  1  one-cycle pulse, store rejected with no memory access.

Behaviour:
- States: IDLE, READ, LATCH, WRITE, DONE, ERR. All outputs are decoded from the registered state and the captured type only (Moore); no combinational path from any input to any output.
- Reset (reset = 0, asynchronous): state goes to IDLE and the latency counter clears.
  - All outputs are 0 immediately, including mid-operation; mem_wr must drop without waiting for a clock edge.
- IDLE with start = 1: store_type and addr_low are captured into internal registers.
  - Legality check, on the captured values:
    - store_type = 11 → illegal.
    - SH with addr_low[0] = 1 → misaligned, illegal.
    - SW with addr_low ≠ 00 → misaligned, illegal.
    - SB → always legal.
  - Illegal → ERR.
  - Legal SW → WRITE.
  - Legal SB/SH → READ, counter loaded with MEM_LAT-1.
- IDLE with start = 0: stay in IDLE.
- READ: mem_rd = 1. The counter decrements each cycle; on the cycle the counter = 0, go to LATCH. READ therefore lasts exactly MEM_LAT cycles.
- LATCH: mdr_load = 1 for one cycle, mem_rd = 0 → WRITE.
- WRITE: mem_wr = 1 for exactly one cycle → DONE.
- DONE: done = 1 for one cycle → IDLE.
- ERR: err = 1 for one cycle; mem_rd, mdr_load and mem_wr stay 0 → IDLE.
- controleSS:
  - Equals the captured type (00/01/10) in READ, LATCH, WRITE and DONE.
  - Is 00 in IDLE and ERR.
  - Must be stable throughout WRITE.
- busy = 1 in READ, LATCH, WRITE, DONE and ERR.
- start while busy is ignored and not queued. A start in the same cycle as done is also ignored.
- Back-to-back: a start in the first IDLE cycle after DONE is accepted.
- Latency, taking the start cycle as 0:
  - SW: mem_wr in cycle 1, done in cycle 2.
  - SB/SH: mem_rd in cycles 1..MEM_LAT, mdr_load in MEM_LAT+1, mem_wr in MEM_LAT+2, done in MEM_LAT+3.
  - Error: err in cycle 1.
- Exclusivity: mem_rd, mdr_load and mem_wr are never high in the same cycle. Exactly one mem_wr pulse per accepted legal store.

Test Plan:
- Reset, then SW: reset held low 3 cycles, release; start = 1, store_type = 00, addr_low = 00 → cycle 1: mem_wr = 1, controleSS = 00; cycle 2: done = 1; busy = 1 in cycles 1-2 only.
- SB, MEM_LAT = 1: start, store_type = 01, addr_low = 11 → mem_rd in cycle 1, mdr_load in cycle 2, mem_wr in cycle 3 with controleSS = 01, done in cycle 4.
- SH, MEM_LAT = 3: start, store_type = 10, addr_low = 10 → mem_rd in cycles 1-3, mdr_load in 4, mem_wr in 5 with controleSS = 10, done in 6.
- Illegal requests:
  - SH with addr_low = 01 → err pulse in cycle 1, no mem_rd/mem_wr ever.
  - store_type = 11 → err pulse in cycle 1, no memory access.
  - SW with addr_low = 10 → err pulse in cycle 1, no memory access.
- Ignored start and back-to-back: start held high during an SB sequence → exactly one mem_wr. A new SW start in the cycle after done → accepted, mem_wr in the next cycle.
- Reset mid-write: assert reset during WRITE between clock edges → mem_wr and controleSS go to 0 immediately. After release: busy = 0, and the next SW start completes normally.
